// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: run-state encoding,
// default parameter values and the decode priority order.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StHalted  = 2'd2,
        StFaulted = 2'd3
    } state_e;

    localparam int unsigned DefPcW        = 10;
    localparam int unsigned DefLutDepth   = 8;
    localparam int unsigned DefStackDepth = 4;
    localparam int unsigned DefStartPc    = 0;

    // Decode priority while running and not stalled; lower number wins.
    // Start sits above all of these, Stall above everything except Start.
    localparam int unsigned PrioHalt = 1;
    localparam int unsigned PrioRet  = 2;
    localparam int unsigned PrioCall = 3;
    localparam int unsigned PrioJump = 4;
    localparam int unsigned PrioIncr = 5;

endpackage

// File: rtl/jump_lut.sv
// Jump target table: one synchronous write port, one combinational read port,
// asynchronously cleared. A same-cycle write and read of one entry returns the
// old value.
module jump_lut
    import pc_seq_pkg::*;
#(
    parameter int unsigned Depth = DefLutDepth,
    parameter int unsigned Width = DefPcW,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wen_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdat_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdat_o
);

    logic [Width-1:0] mem_q [Depth];

    // Table storage: cleared on reset, written on the rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wen_i) begin
            mem_q[waddr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch address generator: increment, LUT-based conditional jump,
// call/return through a hardware return stack, stall hold and a start/halt
// run-state machine driving Done/Fault.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W        = DefPcW,
    parameter int unsigned LUT_DEPTH   = DefLutDepth,
    parameter int unsigned STACK_DEPTH = DefStackDepth,
    parameter int unsigned START_PC    = DefStartPc
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Stall,
    input  logic                         Halt,
    input  logic                         Jen,
    input  logic                         Jcond,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic [$clog2(LUT_DEPTH)-1:0] Jptr,
    input  logic                         LutWen,
    input  logic [$clog2(LUT_DEPTH)-1:0] LutWaddr,
    input  logic [PC_W-1:0]              LutWdat,
    output logic [PC_W-1:0]              PC,
    output logic                         Done,
    output logic                         Fault
);

    localparam int unsigned SpW     = $clog2(STACK_DEPTH + 1);
    localparam int unsigned StkIdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [PC_W-1:0] StartPc = PC_W'(START_PC);
    localparam logic [SpW-1:0]  SpFull  = SpW'(STACK_DEPTH);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [SpW-1:0]      sp_q, sp_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic                push;
    logic [StkIdxW-1:0]  push_idx, pop_idx;
    logic [PC_W-1:0]     lut_rdat;
    logic [PC_W-1:0]     stack_q [STACK_DEPTH];

    jump_lut #(
        .Depth (LUT_DEPTH),
        .Width (PC_W)
    ) u_jump_lut (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .wen_i   (LutWen),
        .waddr_i (LutWaddr),
        .wdat_i  (LutWdat),
        .raddr_i (Jptr),
        .rdat_o  (lut_rdat)
    );

    // sp points at the next free slot; the top of stack is sp-1.
    assign push_idx = StkIdxW'(sp_q);
    assign pop_idx  = StkIdxW'(sp_q - SpW'(1));

    // State register: run state, PC, stack pointer and the registered flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= StartPc;
            sp_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Return stack storage; contents are don't-care after reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_q;
        end
    end

    // Next state: Start overrides everything, then Stall, then the decode priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        if (Start) begin
            state_d = StRun;
            pc_d    = StartPc;
            sp_d    = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!Stall) begin
                        if (Halt) begin
                            state_d = StHalted;
                        end else if (Ret) begin
                            if (sp_q == '0) begin
                                state_d = StFaulted;
                            end else begin
                                pc_d = stack_q[pop_idx] + PC_W'(1);
                                sp_d = sp_q - SpW'(1);
                            end
                        end else if (Call) begin
                            if (sp_q == SpFull) begin
                                state_d = StFaulted;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SpW'(1);
                                pc_d = lut_rdat;
                            end
                        end else if (Jen && Jcond) begin
                            pc_d = lut_rdat;
                        end else begin
                            pc_d = pc_q + PC_W'(1);
                        end
                    end
                end
                StIdle, StHalted, StFaulted: begin
                    // PC held until the next Start.
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs: flags are derived from the next state so they register with it.
    always_comb begin
        done_d  = (state_d == StHalted) || (state_d == StFaulted);
        fault_d = (state_d == StFaulted);
    end

    assign PC    = pc_q;
    assign Done  = done_q;
    assign Fault = fault_q;

endmodule
